// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART TX driver; 4 cycles per byte, 2 cycles req->readclk, stalls in ISSUE while downstream_rdy=0.
// Optional per-grant byte cap enabled by `define UART_ARB_MAXLEN_EN (cap = MAX_PKT_LEN).
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   readclk,
    input  logic [NUM_REQ-1:0]   inclk,
    input  logic [8*NUM_REQ-1:0] in,
    input  logic [NUM_REQ-1:0]   in_last,
    input  logic                 downstream_rdy,
    output logic [7:0]           out,
    output logic                 outclk,
    output logic                 out_last,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_gidx;
    logic [GW-1:0]      r_last_grant;
    logic [GW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_readclk;
    logic [NUM_REQ-1:0] w_readclk_nxt;
    logic [7:0]         r_out;
    logic               r_outclk;
    logic               r_out_last;
    logic               w_take;
    logic               w_cap;
    logic               w_cut;
    logic [7:0]         w_byte;

`ifdef UART_ARB_MAXLEN_EN
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    logic [CW-1:0] r_byte_cnt;

    assign w_cap = ((r_byte_cnt + CW'(1)) == CW'(MAX_PKT_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_byte_cnt <= '0;
        end else if (w_take) begin
            r_byte_cnt <= r_byte_cnt + CW'(1);
        end
    end
`else
    logic w_unused_maxlen;
    assign w_unused_maxlen = (MAX_PKT_LEN != 0);
    assign w_cap           = 1'b0;
`endif

    // Highest k assigned first so the nearest requester after last_grant wins.
    always_comb begin
        logic [GW-1:0] v_idx;
        v_idx      = '0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            v_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (req[v_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = v_idx;
            end
        end
    end

    assign w_byte = in[{r_gidx, 3'b000} +: 8];
    assign w_take = (r_state == S_WAIT) && inclk[r_gidx];
    assign w_cut  = in_last[r_gidx] | w_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pick_vld)     w_state_nxt = S_ISSUE;
            S_ISSUE: if (downstream_rdy) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_take)         w_state_nxt = S_SEND;
            S_SEND:  w_state_nxt = r_out_last ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_readclk_nxt = '0;
        if ((r_state == S_ISSUE) && downstream_rdy) begin
            w_readclk_nxt = r_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readclk    <= '0;
            r_outclk     <= 1'b0;
            r_out_last   <= 1'b0;
            r_out        <= '0;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
        end else begin
            r_readclk  <= w_readclk_nxt;
            r_outclk   <= w_take;
            r_out_last <= w_take ? w_cut : 1'b0;
            if (w_take) begin
                r_out <= w_byte;
            end
            if ((r_state == S_IDLE) && w_pick_vld) begin
                r_gidx  <= w_pick_idx;
                r_grant <= NUM_REQ'(1) << w_pick_idx;
            end
            // out_last is still high during SEND and tells us the grant is over.
            if ((r_state == S_SEND) && r_out_last) begin
                r_last_grant <= r_gidx;
                r_grant      <= '0;
            end
        end
    end

    assign readclk  = r_readclk;
    assign outclk   = r_outclk;
    assign out_last = r_out_last;
    assign out      = r_out;
    assign grant    = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule
